// File: rtl/axi_wr_arbiter_if.sv
// AXI4 single-beat write channels (AW, W, B) shared by the write arbiter and its slave.
// Master drives the address/data/valid fields; slave drives the readies and the response.
interface axi_wr_arbiter_if #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_WDATA_WIDTH   = 32,
   parameter int AXI4_ID_WIDTH      = 16,
   parameter int AXI4_USER_WIDTH    = 10
);
   logic [AXI4_ADDRESS_WIDTH-1:0]   aw_addr_o;
   logic                            aw_valid_o;
   logic                            aw_ready_i;
   logic [AXI4_ID_WIDTH-1:0]        aw_id_o;
   logic [7:0]                      aw_len_o;
   logic [2:0]                      aw_size_o;
   logic [1:0]                      aw_burst_o;
   logic                            aw_lock_o;
   logic [3:0]                      aw_cache_o;
   logic [2:0]                      aw_prot_o;
   logic [3:0]                      aw_region_o;
   logic [AXI4_USER_WIDTH-1:0]      aw_user_o;
   logic [3:0]                      aw_qos_o;

   logic [AXI4_WDATA_WIDTH-1:0]     w_data_o;
   logic [AXI4_WDATA_WIDTH/8-1:0]   w_strb_o;
   logic                            w_last_o;
   logic [AXI4_USER_WIDTH-1:0]      w_user_o;
   logic                            w_valid_o;
   logic                            w_ready_i;

   logic [1:0]                      b_resp_i;
   logic                            b_valid_i;
   logic                            b_ready_o;

   modport master (
      output aw_addr_o, aw_valid_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
             aw_lock_o, aw_cache_o, aw_prot_o, aw_region_o, aw_user_o, aw_qos_o,
             w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o, b_ready_o,
      input  aw_ready_i, w_ready_i, b_resp_i, b_valid_i
   );

   modport slave (
      input  aw_addr_o, aw_valid_o, aw_id_o, aw_len_o, aw_size_o, aw_burst_o,
             aw_lock_o, aw_cache_o, aw_prot_o, aw_region_o, aw_user_o, aw_qos_o,
             w_data_o, w_strb_o, w_last_o, w_user_o, w_valid_o, b_ready_o,
      output aw_ready_i, w_ready_i, b_resp_i, b_valid_i
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 single-beat write port between NREQ requesters.
// A winner's payload is latched in IDLE, then AW/W run in XFER and B completes in RESP.
module axi_wr_arbiter #(
   parameter int NREQ               = 2,
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_WDATA_WIDTH   = 32,
   parameter int AXI4_ID_WIDTH      = 16,
   parameter int AXI4_USER_WIDTH    = 10,
   parameter int AXI_ID             = 4
) (
   input  logic                                 iclk,
   input  logic                                 rst,
   input  logic [NREQ-1:0]                      req_valid_i,
   input  logic [NREQ-1:0]                      req_lock_i,
   input  logic [NREQ*AXI4_ADDRESS_WIDTH-1:0]   req_addr_i,
   input  logic [NREQ*AXI4_WDATA_WIDTH-1:0]     req_data_i,
   output logic [NREQ-1:0]                      req_ack_o,
   output logic [1:0]                           resp_o,
   output logic [NREQ-1:0]                      grant_o,
   output logic                                 busy_o,
   axi_wr_arbiter_if.master                     axi
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                          state_reg, state_next;
   logic [NREQ-1:0]                 grant_reg, grant_next;
   logic [IDX_W-1:0]                last_grant_reg, last_grant_next;
   logic                            locked_reg, locked_next;
   logic [AXI4_ADDRESS_WIDTH-1:0]   addr_reg, addr_next;
   logic [AXI4_WDATA_WIDTH-1:0]     data_reg, data_next;
   logic [1:0]                      resp_reg, resp_next;
   logic                            aw_done_reg, aw_done_next;
   logic                            w_done_reg, w_done_next;

   logic [AXI4_ADDRESS_WIDTH-1:0]   req_addr_arr [NREQ];
   logic [AXI4_WDATA_WIDTH-1:0]     req_data_arr [NREQ];

   logic [IDX_W-1:0]                cand;
   logic [IDX_W-1:0]                rr_idx;
   logic                            rr_found;
   logic                            keep_lock;
   logic                            win_valid;
   logic [IDX_W-1:0]                win_idx;

   logic                            aw_valid;
   logic                            w_valid;
   logic                            b_ready;
   logic                            b_hs;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_addr_arr[gi] = req_addr_i[gi*AXI4_ADDRESS_WIDTH +: AXI4_ADDRESS_WIDTH];
         assign req_data_arr[gi] = req_data_i[gi*AXI4_WDATA_WIDTH +: AXI4_WDATA_WIDTH];
         // The ack is the B handshake itself, routed to whoever owns the bus.
         assign req_ack_o[gi]    = grant_reg[gi] & b_hs;
      end
   endgenerate

   // Search starts one past the previous owner so every requester gets a turn.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      cand     = last_grant_reg;
      for (int i = 0; i < NREQ; i++) begin
         cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + IDX_W'(1);
         if (!rr_found && req_valid_i[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end
      keep_lock = locked_reg && req_valid_i[last_grant_reg];
      win_valid = keep_lock || rr_found;
      win_idx   = keep_lock ? last_grant_reg : rr_idx;
   end

   assign aw_valid = (state_reg == XFER) && !aw_done_reg;
   assign w_valid  = (state_reg == XFER) && !w_done_reg;
   assign b_ready  = (state_reg == RESP);
   assign b_hs     = b_ready && axi.b_valid_i;

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      locked_next     = locked_reg;
      addr_next       = addr_reg;
      data_next       = data_reg;
      resp_next       = resp_reg;
      aw_done_next    = aw_done_reg;
      w_done_next     = w_done_reg;

      case (state_reg)
         IDLE: begin
            // A lock whose owner went away is dropped before normal arbitration.
            if (locked_reg && !keep_lock) begin
               locked_next = 1'b0;
            end
            if (win_valid) begin
               grant_next      = NREQ'(1) << win_idx;
               last_grant_next = win_idx;
               addr_next       = req_addr_arr[win_idx];
               data_next       = req_data_arr[win_idx];
               aw_done_next    = 1'b0;
               w_done_next     = 1'b0;
               state_next      = XFER;
            end
         end

         XFER: begin
            aw_done_next = aw_done_reg | (aw_valid && axi.aw_ready_i);
            w_done_next  = w_done_reg  | (w_valid  && axi.w_ready_i);
            if (aw_done_next && w_done_next) begin
               state_next = RESP;
            end
         end

         RESP: begin
            if (b_hs) begin
               resp_next   = axi.b_resp_i;
               locked_next = req_lock_i[last_grant_reg];
               grant_next  = '0;
               state_next  = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= IDX_W'(NREQ - 1);
         locked_reg     <= 1'b0;
         addr_reg       <= '0;
         data_reg       <= '0;
         resp_reg       <= 2'b00;
         aw_done_reg    <= 1'b0;
         w_done_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         locked_reg     <= locked_next;
         addr_reg       <= addr_next;
         data_reg       <= data_next;
         resp_reg       <= resp_next;
         aw_done_reg    <= aw_done_next;
         w_done_reg     <= w_done_next;
      end
   end

   assign grant_o = grant_reg;
   assign resp_o  = resp_reg;
   assign busy_o  = (state_reg != IDLE);

   // Valids are decoded from state so an asynchronous reset removes them at once.
   assign axi.aw_valid_o  = aw_valid;
   assign axi.aw_addr_o   = addr_reg;
   assign axi.aw_id_o     = AXI4_ID_WIDTH'(AXI_ID);
   assign axi.aw_len_o    = 8'd0;
   assign axi.aw_size_o   = 3'b010;
   assign axi.aw_burst_o  = 2'b00;
   assign axi.aw_lock_o   = 1'b0;
   assign axi.aw_cache_o  = 4'd0;
   assign axi.aw_prot_o   = 3'd0;
   assign axi.aw_region_o = 4'd0;
   assign axi.aw_user_o   = '0;
   assign axi.aw_qos_o    = 4'd0;

   assign axi.w_valid_o   = w_valid;
   assign axi.w_data_o    = data_reg;
   assign axi.w_strb_o    = '1;
   assign axi.w_last_o    = 1'b1;
   assign axi.w_user_o    = AXI4_USER_WIDTH'(AXI_ID);

   assign axi.b_ready_o   = b_ready;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: a delay-programmable AXI slave plus a scoreboard of expected
// completions; table vectors cover single writes, hand sequences cover skew, lock, reset, contention.
module tb_axi_wr_arbiter;
   localparam int NREQ   = 2;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int IDW    = 16;
   localparam int UW     = 10;
   localparam int AXI_ID = 4;

   logic                 iclk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_lock;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_data;
   logic [NREQ-1:0]      req_ack;
   logic [1:0]           resp;
   logic [NREQ-1:0]      grant;
   logic                 busy;

   axi_wr_arbiter_if #(
      .AXI4_ADDRESS_WIDTH(AW), .AXI4_WDATA_WIDTH(DW),
      .AXI4_ID_WIDTH(IDW), .AXI4_USER_WIDTH(UW)
   ) axi ();

   axi_wr_arbiter #(
      .NREQ(NREQ), .AXI4_ADDRESS_WIDTH(AW), .AXI4_WDATA_WIDTH(DW),
      .AXI4_ID_WIDTH(IDW), .AXI4_USER_WIDTH(UW), .AXI_ID(AXI_ID)
   ) dut (
      .iclk        (iclk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_lock_i  (req_lock),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_ack_o   (req_ack),
      .resp_o      (resp),
      .grant_o     (grant),
      .busy_o      (busy),
      .axi         (axi)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   typedef struct {
      int          req;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   typedef struct {
      int          req;
      logic [31:0] addr;
      logic [31:0] data;
      int          aw_d;
      int          w_d;
      int          b_d;
      logic [1:0]  bresp;
      int          lat;
   } vec_t;

   exp_t        sb[$];
   logic [31:0] aw_seen[$];
   logic [31:0] w_seen[$];

   int          tests = 0;
   int          fails = 0;
   int          ack_total = 0;
   int          ack_per[NREQ];
   int          aw_dly = 0;
   int          w_dly = 0;
   int          b_dly = 0;
   logic [1:0]  bresp_cfg = 2'b00;
   int          aw_cnt = 0;
   int          w_cnt = 0;
   int          b_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic drive_req(input int k, input logic v, input logic l,
                            input logic [31:0] a, input logic [31:0] d);
      req_valid[k]         = v;
      req_lock[k]          = l;
      req_addr[k*AW +: AW] = a;
      req_data[k*DW +: DW] = d;
   endtask

   // Returns the number of negedges waited; a missing ack is a failed comparison.
   task automatic wait_acks(input int n, output int cyc);
      int start;
      start = ack_total;
      cyc   = 0;
      while (ack_total < start + n && cyc < 100) begin
         @(negedge iclk);
         #2;
         cyc++;
      end
      tests++;
      if (ack_total < start + n) begin
         fails++;
         $display("FAIL ack_timeout: saw %0d acks, expected %0d", ack_total - start, n);
      end
   endtask

   // Slave model and scoreboard: readies change on the falling edge, checks run 1 time unit later.
   initial begin
      exp_t       e;
      logic       pend_resp;
      logic [1:0] pend_val;
      pend_resp = 1'b0;
      pend_val  = 2'b00;
      for (int k = 0; k < NREQ; k++) ack_per[k] = 0;
      axi.aw_ready_i = 1'b0;
      axi.w_ready_i  = 1'b0;
      axi.b_valid_i  = 1'b0;
      axi.b_resp_i   = 2'b00;
      forever begin
         @(negedge iclk);
         if (axi.aw_valid_o) begin axi.aw_ready_i = (aw_cnt >= aw_dly); aw_cnt++; end
         else begin axi.aw_ready_i = 1'b0; aw_cnt = 0; end
         if (axi.w_valid_o) begin axi.w_ready_i = (w_cnt >= w_dly); w_cnt++; end
         else begin axi.w_ready_i = 1'b0; w_cnt = 0; end
         if (axi.b_ready_o) begin axi.b_valid_i = (b_cnt >= b_dly); b_cnt++; end
         else begin axi.b_valid_i = 1'b0; b_cnt = 0; end
         axi.b_resp_i = bresp_cfg;
         #1;
         if (pend_resp) begin
            check("resp_o", resp, pend_val);
            pend_resp = 1'b0;
         end
         if (rst) begin
            aw_seen.delete();
            w_seen.delete();
         end else begin
            if (axi.aw_valid_o && axi.aw_ready_i) aw_seen.push_back(axi.aw_addr_o);
            if (axi.w_valid_o && axi.w_ready_i) w_seen.push_back(axi.w_data_o);
         end
         if (axi.b_valid_i && axi.b_ready_o) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack: ack=%b with empty scoreboard", req_ack);
            end else begin
               e = sb.pop_front();
               check("ack_vec", req_ack, 64'(1) << e.req);
               check("grant_at_ack", grant, 64'(1) << e.req);
               check("aw_beats", aw_seen.size(), 1);
               check("w_beats", w_seen.size(), 1);
               if (aw_seen.size() > 0) check("aw_addr", aw_seen[0], e.addr);
               if (w_seen.size() > 0) check("w_data", w_seen[0], e.data);
               pend_resp = 1'b1;
               pend_val  = e.resp;
               ack_per[e.req]++;
               $display("[TB] ack req=%0d addr=0x%08h data=0x%08h resp=%0d",
                        e.req, e.addr, e.data, e.resp);
            end
            aw_seen.delete();
            w_seen.delete();
            ack_total++;
         end else begin
            check("ack_idle", req_ack, 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vt[6];
      int   lat;
      int   start;
      int   a0;
      int   a1;

      rst       = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_data  = '0;

      vt[0] = '{0, 32'h0A10200C, 32'h000007FF, 0, 0, 0, 2'b00, 2};
      vt[1] = '{1, 32'h10000004, 32'hDEADBEEF, 0, 0, 0, 2'b00, 2};
      vt[2] = '{0, 32'h20000000, 32'hA5A5A5A5, 1, 0, 0, 2'b00, 3};
      vt[3] = '{1, 32'h30000010, 32'h12345678, 0, 2, 1, 2'b01, 5};
      vt[4] = '{0, 32'hFFFFFFFC, 32'hFFFFFFFF, 0, 0, 0, 2'b10, 2};
      vt[5] = '{1, 32'h00000000, 32'h00000000, 0, 0, 0, 2'b11, 2};

      repeat (3) @(negedge iclk);
      #2;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_awv", axi.aw_valid_o, 0);
      check("rst_wv", axi.w_valid_o, 0);
      check("rst_bready", axi.b_ready_o, 0);
      check("rst_ack", req_ack, 0);
      check("rst_resp", resp, 0);
      check("rst_addr", axi.aw_addr_o, 0);
      check("aw_id", axi.aw_id_o, AXI_ID);
      check("aw_size", axi.aw_size_o, 3'b010);
      check("aw_len", axi.aw_len_o, 0);
      check("w_strb", axi.w_strb_o, 4'hF);
      check("w_last", axi.w_last_o, 1);
      check("w_user", axi.w_user_o, AXI_ID);
      @(negedge iclk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         @(negedge iclk);
         aw_dly    = vt[i].aw_d;
         w_dly     = vt[i].w_d;
         b_dly     = vt[i].b_d;
         bresp_cfg = vt[i].bresp;
         sb.push_back('{vt[i].req, vt[i].addr, vt[i].data, vt[i].bresp});
         drive_req(vt[i].req, 1'b1, 1'b0, vt[i].addr, vt[i].data);
         wait_acks(1, lat);
         check("latency", lat, vt[i].lat);
         @(negedge iclk);
         #2;
         req_valid[vt[i].req] = 1'b0;
         check("idle_busy", busy, 0);
         check("idle_grant", grant, 0);
      end

      // Skewed handshakes, with the payload disturbed after the grant.
      @(negedge iclk);
      aw_dly    = 3;
      w_dly     = 0;
      b_dly     = 2;
      bresp_cfg = 2'b00;
      sb.push_back('{0, 32'hCAFE0000, 32'h0BADF00D, 2'b00});
      drive_req(0, 1'b1, 1'b0, 32'hCAFE0000, 32'h0BADF00D);
      start = ack_total;
      for (int c = 1; c <= 7; c++) begin
         @(negedge iclk);
         #2;
         check("skew_addr", axi.aw_addr_o, 32'hCAFE0000);
         check("skew_data", axi.w_data_o, 32'h0BADF00D);
         check("skew_awv", axi.aw_valid_o, c <= 4);
         check("skew_wv", axi.w_valid_o, c == 1);
         check("skew_bready", axi.b_ready_o, c >= 5);
         check("skew_ack", req_ack, (c == 7) ? 2'b01 : 2'b00);
         if (c == 2) drive_req(0, 1'b1, 1'b0, 32'h11111111, 32'h22222222);
      end
      check("skew_ack_count", ack_total - start, 1);
      @(negedge iclk);
      req_valid[0] = 1'b0;

      // Lock: requester 1 keeps the bus once, then releases it to requester 0.
      @(negedge iclk);
      aw_dly    = 0;
      w_dly     = 0;
      b_dly     = 0;
      bresp_cfg = 2'b01;
      sb.push_back('{1, 32'h40000000, 32'h000000A1, 2'b01});
      sb.push_back('{1, 32'h40000004, 32'h000000B2, 2'b01});
      sb.push_back('{0, 32'h50000000, 32'h000000C3, 2'b01});
      drive_req(1, 1'b1, 1'b1, 32'h40000000, 32'h000000A1);
      @(negedge iclk);
      drive_req(0, 1'b1, 1'b0, 32'h50000000, 32'h000000C3);
      wait_acks(1, lat);
      @(negedge iclk);
      drive_req(1, 1'b1, 1'b0, 32'h40000004, 32'h000000B2);
      wait_acks(1, lat);
      @(negedge iclk);
      req_valid[1] = 1'b0;
      wait_acks(1, lat);
      @(negedge iclk);
      req_valid[0] = 1'b0;

      // Reset in the middle of XFER abandons the write without an ack.
      @(negedge iclk);
      aw_dly    = 20;
      w_dly     = 20;
      bresp_cfg = 2'b00;
      drive_req(1, 1'b1, 1'b0, 32'h55550000, 32'h66660000);
      @(negedge iclk);
      @(negedge iclk);
      #2;
      check("pre_rst_awv", axi.aw_valid_o, 1);
      check("pre_rst_grant", grant, 2'b10);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_awv", axi.aw_valid_o, 0);
      check("mid_rst_wv", axi.w_valid_o, 0);
      check("mid_rst_bready", axi.b_ready_o, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_grant", grant, 0);
      check("mid_rst_ack", req_ack, 0);
      check("mid_rst_resp", resp, 0);
      aw_dly = 0;
      w_dly  = 0;
      drive_req(0, 1'b1, 1'b0, 32'h60000000, 32'h00000D00);
      drive_req(1, 1'b1, 1'b0, 32'h70000000, 32'h00000E00);
      sb.push_back('{0, 32'h60000000, 32'h00000D00, 2'b00});
      sb.push_back('{1, 32'h70000000, 32'h00000E00, 2'b00});
      sb.push_back('{0, 32'h60000000, 32'h00000D00, 2'b00});
      sb.push_back('{1, 32'h70000000, 32'h00000E00, 2'b00});
      a0 = ack_per[0];
      a1 = ack_per[1];
      @(negedge iclk);
      @(negedge iclk);
      rst = 1'b0;

      // Contention after reset: requester 0 first, then strict alternation.
      wait_acks(3, lat);
      @(negedge iclk);
      req_valid[0] = 1'b0;
      wait_acks(1, lat);
      @(negedge iclk);
      req_valid[1] = 1'b0;
      check("cont_acks_r0", ack_per[0] - a0, 2);
      check("cont_acks_r1", ack_per[1] - a1, 2);
      repeat (3) @(negedge iclk);
      #2;
      check("sb_drained", sb.size(), 0);
      check("final_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Round-robin arbiter and sequencer that shares one AXI4 single-beat write master port between `NREQ` internal requesters, such as the camera FIFO drain path and the SPI address/command writer. Each requester presents an address/data pair. The block grants one requester, latches its payload, runs the AW, W and B phases, and returns a one-cycle acknowledge with the write response. A lock input lets a requester keep the bus for back-to-back dependent writes (address write followed by TXFIFO write).

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8
- `AXI4_ADDRESS_WIDTH`, 32: address width
- `AXI4_WDATA_WIDTH`, 32: data width
- `AXI4_ID_WIDTH`, 16: ID width
- `AXI4_USER_WIDTH`, 10: user width
- `AXI_ID`, 4: constant value driven on `aw_id_o`

Ports:
- `iclk` in 1: clock; one clock for the whole block.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid_i` in NREQ: write request per requester.
- `req_lock_i` in NREQ: retain grant after this write.
- `req_addr_i` in NREQ*AXI4_ADDRESS_WIDTH: packed addresses; requester k occupies slice k.
- `req_data_i` in NREQ*AXI4_WDATA_WIDTH: packed write data.
- `req_ack_o` out NREQ: one-cycle completion pulse to the granted requester.
- `resp_o` out 2: `b_resp_i` captured at the last completion.
- `grant_o` out NREQ: one-hot current owner; 0 when idle.
- `busy_o` out 1: high in any state other than IDLE.
- `aw_addr_o` out AXI4_ADDRESS_WIDTH, `aw_valid_o` out 1, `aw_ready_i` in 1: AXI write address channel.
- `aw_id_o`, `aw_len_o`, `aw_size_o`, `aw_burst_o`, `aw_lock_o`, `aw_cache_o`, `aw_prot_o`, `aw_region_o`, `aw_user_o`, `aw_qos_o`: constant AW fields.
- `w_data_o` out AXI4_WDATA_WIDTH, `w_strb_o` out AXI4_WDATA_WIDTH/8, `w_last_o` out 1, `w_user_o` out AXI4_USER_WIDTH, `w_valid_o` out 1, `w_ready_i` in 1: AXI write data channel.
- `b_resp_i` in 2, `b_valid_i` in 1, `b_ready_o` out 1: AXI write response channel.

## Operation
- Constant outputs:
  - `aw_id_o`=AXI_ID, `aw_len_o`=0, `aw_size_o`=3'b010, `aw_burst_o`=2'b00.
  - `aw_lock_o`, `aw_cache_o`, `aw_prot_o`, `aw_region_o`, `aw_user_o`, `aw_qos_o` = 0.
  - `w_strb_o` all ones, `w_last_o`=1, `w_user_o`=AXI_ID.
- FSM states: IDLE, XFER, RESP.
- IDLE:
  - If any `req_valid_i` bit is high, pick a winner (see arbitration).
  - Latch the winner's address and data into internal registers.
  - Set `grant_o` to the winner and go to XFER.
- XFER:
  - `aw_valid_o` and `w_valid_o` assert together.
  - Each drops after its own handshake (valid&&ready); flags `aw_done`/`w_done` record completion.
  - When both phases are complete, go to RESP.
- RESP:
  - `b_ready_o`=1.
  - On `b_valid_i`: `req_ack_o[g]`=1 in that same cycle (combinational from `b_valid_i`&&`b_ready_o`); `resp_o`<=`b_resp_i`; sample `req_lock_i[g]` into `locked`; go to IDLE.
- Arbitration:
  - If `locked` and `req_valid_i[g]`, regrant g.
  - Otherwise use round-robin starting at (last_grant+1) mod NREQ.
  - If `locked` is set but `req_valid_i[g]`=0 in IDLE, clear `locked` and arbitrate normally.
- `aw_addr_o`/`w_data_o` come from the latched registers; they are stable for the whole transaction.
- A `b_resp_i` error (SLVERR/DECERR) is only reported on `resp_o`. There is no retry.

## Timing
- Reset (async, immediate) values:
  - state IDLE; `aw_valid_o`, `w_valid_o`, `b_ready_o`, `busy_o` = 0.
  - `grant_o`, `req_ack_o`, `resp_o` = 0; `locked`=0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - Latched address/data = 0.
- Reset mid-transaction: valids drop at once, no ack is issued, and the transaction is abandoned.
- Minimum latency with ready signals high:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: AW and W handshake.
  - Cycle 2: RESP; B handshake and ack if `b_valid_i`=1.
  - Cycle 3: IDLE; the next grant is decided.
- AW and W handshakes may complete in either order or together. Neither valid is ever re-asserted after its handshake within one transaction.
- Valids never drop before their handshake. Stalling `aw_ready_i`/`w_ready_i`/`b_valid_i` holds the FSM indefinitely; there is no timeout.
- Requesters must not change `req_valid_i` and payload until ack. A payload change after grant has no effect.
- A requester sees its ack in the B-handshake cycle and may drop or re-present its request in the next cycle.

## Test plan
- Single request: requester 0 writes addr 0x0A10200C, data 0x000007FF, all readies high. Expected: one AW/W beat at cycle 1, `req_ack_o`=2'b01 at cycle 2, `resp_o`=0.
- Contention: both requesters hold valid for 4 writes. Expected: grants alternate 0,1,0,1; each receives exactly 2 acks.
- Lock: requester 1 writes with lock=1, then lock=0, while requester 0 is continuously valid. Expected: two consecutive grants to 1, then a grant to 0.
- Skewed handshakes: `aw_ready_i` delayed 3 cycles, `w_ready_i` immediate, `b_valid_i` delayed 2 cycles. Expected: `w_valid_o` drops at cycle 2, `aw_valid_o` drops after cycle 4, ack after `b_valid_i`, addr/data unchanged throughout.
- Error response: `b_resp_i`=2'b10. Expected: `resp_o`=2'b10 after ack and the FSM returns to IDLE.
- Reset mid-XFER: assert `rst` with `aw_valid_o` high. Expected: all outputs 0 immediately, no ack; after release, requester 0 wins first.
